// File: rtl/pcu_pkg.sv
// Shared definitions for the PC/nPC unit: next-PC source select codes and the sequencing states.
package pcu_pkg;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_TA  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pcu_state_t;

endpackage

// File: rtl/pcu_target_mux.sv
// Fixed-priority next-PC source select (Jmpl > Call/taken branch > sequential) and target mux.
module pcu_target_mux
    import pcu_pkg::*;
#(
    parameter int unsigned AW   = 32,
    parameter int unsigned STEP = 4
) (
    input  logic          jmpl,
    input  logic          call,
    input  logic          branch,
    input  logic          taken,
    input  logic [AW-1:0] ta,
    input  logic [AW-1:0] alu_out,
    input  logic [AW-1:0] npc,
    output logic [1:0]    sel,
    output logic [AW-1:0] seq,
    output logic [AW-1:0] target
);

    assign seq = npc + AW'(STEP);

    always_comb begin
        sel = SEL_SEQ;
        if (jmpl) begin
            sel = SEL_ALU;
        end else if (call || (branch && taken)) begin
            sel = SEL_TA;
        end
    end

    always_comb begin
        target = seq;
        case (sel)
            SEL_TA:  target = ta;
            SEL_ALU: target = alu_out;
            default: target = seq;
        endcase
    end

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC pair with delayed-branch sequencing, one-entry stall redirect buffer and registered annul flag.
// Optional build macro PCU_ALIGN_CHECK_EN rejects misaligned non-sequential targets.
module pc_npc_unit
    import pcu_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   STEP     = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          le,
    input  logic          jmpl_i,
    input  logic          call_i,
    input  logic          branch_i,
    input  logic          taken_i,
    input  logic          annul_bit_i,
    input  logic [AW-1:0] ta_i,
    input  logic [AW-1:0] alu_out_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] npc_o,
    output logic [1:0]    sel_o,
    output logic          fetch_valid_o,
    output logic          annul_o,
    output logic          redirect_pending_o,
    output logic          misalign_o
);

    pcu_state_t    state, state_next;
    logic [AW-1:0] pc, npc;
    logic [AW-1:0] seq, target;
    logic [AW-1:0] buf_target;
    logic          buf_annul;
    logic          annul;
    logic          annul_cond;
    logic [AW-1:0] candidate;
    logic [AW-1:0] npc_apply;
    logic          advance;

    pcu_target_mux #(
        .AW   (AW),
        .STEP (STEP)
    ) u_mux (
        .jmpl    (jmpl_i),
        .call    (call_i),
        .branch  (branch_i),
        .taken   (taken_i),
        .ta      (ta_i),
        .alu_out (alu_out_i),
        .npc     (npc),
        .sel     (sel_o),
        .seq     (seq),
        .target  (target)
    );

    assign annul_cond = branch_i & annul_bit_i & ~taken_i;
    assign advance    = le && (state != BOOT);

    // On HOLD exit the buffered redirect replaces the live target; live inputs are the same instruction re-presented.
    assign candidate = (state == HOLD) ? buf_target : target;

`ifdef PCU_ALIGN_CHECK_EN
    localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);

    logic nonseq;
    logic bad_align;
    logic misalign;

    assign nonseq    = (state == HOLD) || (sel_o != SEL_SEQ);
    assign bad_align = nonseq && ((candidate & ALIGN_MASK) != '0);
    assign npc_apply = bad_align ? seq : candidate;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            misalign <= 1'b0;
        end else begin
            misalign <= advance && bad_align;
        end
    end

    assign misalign_o = misalign;
`else
    assign npc_apply  = candidate;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN:  if (!le && (sel_o != SEL_SEQ)) state_next = HOLD;
            HOLD: if (le) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid_o      = (state != BOOT);
        redirect_pending_o = (state == HOLD);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc         <= RESET_PC;
            npc        <= RESET_PC + AW'(STEP);
            buf_target <= '0;
            buf_annul  <= 1'b0;
            annul      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (le) begin
                        pc    <= npc;
                        npc   <= npc_apply;
                        annul <= annul_cond;
                    end else if (sel_o != SEL_SEQ) begin
                        buf_target <= target;
                        buf_annul  <= annul_cond;
                    end
                end
                HOLD: begin
                    if (le) begin
                        pc    <= npc;
                        npc   <= npc_apply;
                        annul <= buf_annul;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_o    = pc;
    assign npc_o   = npc;
    assign annul_o = annul;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed scoreboard bench for pc_npc_unit: a 32-bit instance plus an 8-bit instance for wrap-around.
module tb_pc_npc_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        le = 1'b1;
    logic        jmpl = 1'b0, call = 1'b0, branch = 1'b0, taken = 1'b0, abit = 1'b0;
    logic [31:0] ta = '0, alu = '0;
    logic [31:0] pc, npc;
    logic [1:0]  sel;
    logic        fv, an, pend, mis;

    logic [7:0]  pc8, npc8;
    logic [1:0]  sel8;
    logic        fv8, an8, pend8, mis8;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        fv;
        logic        an;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    pc_npc_unit #(.AW(32), .STEP(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .clr(clr), .le(le),
        .jmpl_i(jmpl), .call_i(call), .branch_i(branch), .taken_i(taken), .annul_bit_i(abit),
        .ta_i(ta), .alu_out_i(alu),
        .pc_o(pc), .npc_o(npc), .sel_o(sel), .fetch_valid_o(fv), .annul_o(an),
        .redirect_pending_o(pend), .misalign_o(mis)
    );

    pc_npc_unit #(.AW(8), .STEP(4), .RESET_PC(8'hF8)) dut8 (
        .clk(clk), .clr(clr), .le(1'b1),
        .jmpl_i(1'b0), .call_i(1'b0), .branch_i(1'b0), .taken_i(1'b0), .annul_bit_i(1'b0),
        .ta_i(8'h00), .alu_out_i(8'h00),
        .pc_o(pc8), .npc_o(npc8), .sel_o(sel8), .fetch_valid_o(fv8), .annul_o(an8),
        .redirect_pending_o(pend8), .misalign_o(mis8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                             input logic e_fv, input logic e_an, input logic e_pend, input logic e_mis);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.npc = e_npc;
        e.fv = e_fv; e.an = e_an; e.pend = e_pend; e.mis = e_mis;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pc"},   pc,   e.pc);
            chk({e.tag, ".npc"},  npc,  e.npc);
            chk({e.tag, ".fv"},   {31'd0, fv},   {31'd0, e.fv});
            chk({e.tag, ".an"},   {31'd0, an},   {31'd0, e.an});
            chk({e.tag, ".pend"}, {31'd0, pend}, {31'd0, e.pend});
            chk({e.tag, ".mis"},  {31'd0, mis},  {31'd0, e.mis});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic clear_ctl();
        jmpl = 1'b0; call = 1'b0; branch = 1'b0; taken = 1'b0; abit = 1'b0;
    endtask

    initial begin
        #12;
        clr = 1'b0;
        expect_st("reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        compare_head();
        chk("w8_reset_pc", {24'd0, pc8}, 32'hF8);
        chk("w8_reset_npc", {24'd0, npc8}, 32'hFC);

        expect_st("boot", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("w8_boot_npc", {24'd0, npc8}, 32'hFC);
        expect_st("seq1", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("w8_wrap_pc", {24'd0, pc8}, 32'hFC);
        chk("w8_wrap_npc", {24'd0, npc8}, 32'h00);
        expect_st("seq2", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("w8_post_wrap_npc", {24'd0, npc8}, 32'h04);

        // Call: redirect lands after the delay slot
        call = 1'b1; ta = 32'h100;
        #1 chk("sel_call", {30'd0, sel}, 32'h1);
        expect_st("call", 32'hC, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ctl();
        expect_st("call_slot", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        jmpl = 1'b1; call = 1'b1; alu = 32'h200; ta = 32'h300;
        #1 chk("sel_jmpl_call", {30'd0, sel}, 32'h2);
        expect_st("jmpl", 32'h104, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ctl();
        #1 chk("sel_seq", {30'd0, sel}, 32'h0);
        expect_st("jmpl_slot", 32'h200, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Stall with a taken branch: buffered target wins over later ta_i changes
        le = 1'b0; branch = 1'b1; taken = 1'b1; ta = 32'h40;
        expect_st("hold1", 32'h200, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        ta = 32'h80;
        expect_st("hold2", 32'h200, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        expect_st("hold3", 32'h200, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        le = 1'b1;
        expect_st("hold_exit", 32'h204, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ctl();
        expect_st("after_hold", 32'h40, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Annul: one le cycle, held across a sequential stall
        branch = 1'b1; abit = 1'b1;
        expect_st("annul_set", 32'h44, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ctl();
        expect_st("annul_clr", 32'h48, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        branch = 1'b1; abit = 1'b1;
        expect_st("annul_set2", 32'h4C, 32'h50, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ctl(); le = 1'b0;
        expect_st("annul_hold1", 32'h4C, 32'h50, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_st("annul_hold2", 32'h4C, 32'h50, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        le = 1'b1;
        expect_st("annul_clr2", 32'h50, 32'h54, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Enter HOLD with annul set, then asynchronous reset mid-HOLD
        branch = 1'b1; abit = 1'b1;
        expect_st("annul_set3", 32'h54, 32'h58, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ctl(); le = 1'b0; call = 1'b1; ta = 32'h60;
        expect_st("hold_annul", 32'h54, 32'h58, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        clear_ctl();
        #2 clr = 1'b1;
        #1;
        expect_st("async_reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        compare_head();
        #3 clr = 1'b0; le = 1'b1;

        expect_st("boot2", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Misaligned call target
        call = 1'b1; ta = 32'h102;
`ifdef PCU_ALIGN_CHECK_EN
        expect_st("misalign", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        clear_ctl();
        expect_st("misalign_end", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
`else
        expect_st("misalign", 32'h4, 32'h102, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ctl();
        expect_st("misalign_end", 32'h102, 32'h106, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
`endif

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
Parametrised successor to the PC/nPC handler, mux and register pair. It holds PC and nPC with delayed-branch semantics and selects the next nPC source (sequential, TA or ALU_OUT) with fixed priority. It adds three things the old split blocks lacked: a stall-safe one-entry redirect buffer, a registered delay-slot annul flag, and a boot cycle. It sits between the ID-stage control signals and the instruction-fetch address port.

Parameters:
AW, 32, address width in bits.
STEP, 4, byte increment per instruction; must be a power of two.
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+STEP.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  reset, asynchronous, active-high.
le  in  1  load enable; 0 = pipeline stall.
jmpl_i  in  1  ID instruction is Jmpl.
call_i  in  1  ID instruction is Call.
branch_i  in  1  ID instruction is a conditional branch.
taken_i  in  1  branch condition true; meaningful only with branch_i.
annul_bit_i  in  1  branch a-bit.
ta_i  in  AW  target address.
alu_out_i  in  AW  Jmpl target.
pc_o  out  AW  current PC (fetch address).
npc_o  out  AW  next PC.
sel_o  out  2  combinational source select: 00 seq, 01 TA, 10 ALU.
fetch_valid_o  out  1  pc_o is a valid fetch.
annul_o  out  1  the instruction at pc_o is annulled.
redirect_pending_o  out  1  buffered redirect held.
misalign_o  out  1  misaligned target flag; optional feature only.

Behaviour:
- Reset (async, any state, mid-stall included): pc_o=RESET_PC, npc_o=RESET_PC+STEP, annul_o=0, redirect_pending_o=0, fetch_valid_o=0, misalign_o=0, state BOOT.
- sel_o priority (combinational from inputs): jmpl_i → 10; else call_i | (branch_i & taken_i) → 01; else 00. Encoding 11 is never produced.
- Target: 00 → npc_o+STEP; 01 → ta_i; 10 → alu_out_i. All arithmetic is modulo 2^AW; wrap-around is silent.
- States: BOOT, RUN, HOLD.
- BOOT: lasts one cycle regardless of le. pc and npc are held. Next state is RUN, and fetch_valid_o goes 1 from then on.
- RUN, le=1, on the clock edge: pc<=npc; npc<=target. Latency is one cycle; the redirect takes effect after the delay slot.
- RUN, le=0, sel_o≠00: capture target into the buffer, set redirect_pending_o=1, go to HOLD. pc and npc are held.
- RUN, le=0, sel_o=00: hold everything, stay in RUN, no capture.
- HOLD, le=0: hold everything; inputs are ignored; buffer contents are unchanged.
- HOLD, le=1: pc<=npc; npc<=buffer; redirect_pending_o<=0; go to RUN. Live inputs that cycle are ignored, because the buffered instruction is the same one being re-presented.
- Annul: on an le=1 edge in RUN, annul_o<=branch_i & annul_bit_i & ~taken_i. In HOLD the annul condition is captured with the buffer and applied on exit. annul_o clears on the next le=1 edge. While le=0, annul_o holds its value. The module does not alter pc; the downstream stage squashes.
- Simultaneous jmpl_i and call_i: ALU_OUT wins.
- fetch_valid_o stays 1 during stalls; the consumer gates the fetch with le.

Optional Feature:
PCU_ALIGN_CHECK_EN.
- Defined: a non-sequential target with any of its low log2(STEP) bits non-zero is not taken. npc<=npc+STEP instead. misalign_o pulses 1 for one cycle on that edge, and this also applies on HOLD exit. The buffer still captures the raw target, and the check is done on apply.
- Undefined: misalign_o is tied 0; targets are used unmodified.

Decomposition:
- Package pcu_pkg: SEL_SEQ=2'b00, SEL_TA=2'b01, SEL_ALU=2'b10; state enum {BOOT, RUN, HOLD}.
- One sub-module, pcu_target_mux: combinational priority select plus target mux, parametrised by AW and STEP.

Test Plan:
- Reset then release, le=1: cycle 0 fetch_valid=0, pc=0, npc=4. Cycle 1 fetch_valid=1. Then pc=4/npc=8, pc=8/npc=12.
- At pc=8/npc=12, call_i=1, ta_i=0x100: sel_o=01. Next edge pc=12/npc=0x100; following edge pc=0x100/npc=0x104.
- jmpl_i=call_i=1, alu_out_i=0x200, ta_i=0x300: sel_o=10. npc becomes 0x200.
- Stall: le=0 with branch taken, ta_i=0x40 → redirect_pending_o=1, pc/npc frozen for 3 cycles. Change ta_i to 0x80 during the stall; it is ignored. le=1 → npc=0x40, pending=0.
- branch_i=1, taken_i=0, annul_bit_i=1 → annul_o=1 for exactly one le cycle. Repeat with le=0 between: annul_o holds. Assert clr mid-HOLD → all outputs reset immediately, without waiting for a clock edge.
- AW=8, pc=0xF8/npc=0xFC, sequential → npc wraps to 0x00. With PCU_ALIGN_CHECK_EN, ta_i=0x102 → misalign_o=1 for one cycle, npc=seq+4.
